// File: rtl/cgp_module.sv
// Autonomous evolved-logic generator: an 8-bit LFSR and a 3-bit counter feed a
// fixed combinational graph whose result is registered onto out_0.
module cgp_module #(
   parameter logic [7:0] SEED = 8'h01
) (
   input  logic clk,
   input  logic reset,
   output logic out_0
);

   // An all-zero LFSR would lock up, so a zero seed is promoted to 8'h01.
   localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

   logic [7:0] s;
   logic [2:0] c;
   logic       fb;
   logic       n0, n1, n2, n3, n4, n5;

   // x^8+x^6+x^5+x^4+1, shifted left with feedback entering at bit 0
   always_comb begin
      fb = s[7] ^ s[5] ^ s[4] ^ s[3];
      n0 = s[0] ^ s[7];
      n1 = s[1] & c[0];
      n2 = n0 | n1;
      n3 = ~(s[3] & c[1]);
      n4 = n2 & n3;
      n5 = n4 ^ c[2];
   end

   // out_0 samples the graph built from the pre-edge s and c.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s     <= SEED_EFF;
         c     <= 3'd0;
         out_0 <= 1'b0;
      end else begin
         s     <= {s[6:0], fb};
         c     <= c + 3'd1;
         out_0 <= n5;
      end
   end

endmodule

// File: tb/tb_cgp_module.sv
// Directed bench for cgp_module: power-up trace, async mid-run reset, reset held
// across edges, a 5000-cycle reference comparison and a 2040-cycle period check.
module tb_cgp_module;

   logic clk;
   logic reset;
   logic out_0;

   int vectors;
   int miscompares;

   logic       exp_out [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [7:0] exp_s   [7] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};

   logic hist [5000];

   cgp_module #(.SEED(8'h01)) dut (
      .clk   (clk),
      .reset (reset),
      .out_0 (out_0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out"}, {7'd0, out_0}, 8'h00);
      check({tag, "_s"}, dut.s, 8'h01);
      check({tag, "_c"}, {5'd0, dut.c}, 8'h00);
   endtask

   // Walks n edges after a release and compares against the hand-derived trace.
   task automatic run_seq(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("%s_out_e%0d", tag, i + 1), {7'd0, out_0}, {7'd0, exp_out[i]});
         if (i < 7) check($sformatf("%s_s_e%0d", tag, i + 1), dut.s, exp_s[i]);
         if (i == 7) check($sformatf("%s_c_wrap", tag), {5'd0, dut.c}, 8'h00);
      end
   endtask

   function automatic logic model_out(input logic [7:0] ms, input logic [2:0] mc);
      logic a, b, d, e;
      a = ms[0] ^ ms[7];
      b = ms[1] & mc[0];
      d = ~(ms[3] & mc[1]);
      e = (a | b) & d;
      return e ^ mc[2];
   endfunction

   initial begin
      logic [7:0] ms;
      logic [2:0] mc;
      logic       mo;
      vectors     = 0;
      miscompares = 0;

      // Power-up: reset high for 10 ns; the edge at 5 ns must not disturb state.
      reset = 1'b1;
      #1;
      check_reset_state("por_t1");
      #5;
      check_reset_state("por_held_edge");
      #4;
      reset = 1'b0;
      run_seq(8, "por");

      // Mid-run reset after edge 5, held across an edge, then restart.
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      run_seq(5, "pre_mid");
      #2;
      reset = 1'b1;
      #1;
      check_reset_state("mid_async");
      @(posedge clk);
      #1;
      check_reset_state("mid_held_edge");
      @(posedge clk);
      #1;
      check_reset_state("mid_held_edge2");
      @(negedge clk);
      reset = 1'b0;
      run_seq(8, "restart");

      // Long run against the reference model from a fresh reset.
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      ms = 8'h01;
      mc = 3'd0;
      for (int i = 0; i < 5000; i++) begin
         mo = model_out(ms, mc);
         ms = {ms[6:0], ms[7] ^ ms[5] ^ ms[4] ^ ms[3]};
         mc = mc + 3'd1;
         @(posedge clk);
         #1;
         hist[i] = out_0;
         check($sformatf("model_out_%0d", i), {7'd0, out_0}, {7'd0, mo});
         check($sformatf("model_s_%0d", i), dut.s, ms);
         check($sformatf("s_nonzero_%0d", i), {7'd0, (dut.s != 8'h00)}, 8'h01);
      end
      for (int i = 0; i < 2040; i++) begin
         check($sformatf("period_%0d", i), {7'd0, hist[i + 2040]}, {7'd0, hist[i]});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
